// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: XLEN, NOP encoding, and the {pc,instr} pair carried through the fetch buffer.
// Pure declarations; no latency or backpressure of its own.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pair_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_prefetch_if.sv
// Bundle of redirect, instruction-memory and decode handshakes around the prefetch unit.
// master = prefetch unit, slave = surrounding pipeline/memory.
interface if_prefetch_if;
    import cpu_pkg::*;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_addr;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;

    modport master (
        input  redirect_valid, redirect_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  id_ready,
        output imem_req_valid, imem_req_addr,
        output id_valid, id_instr, id_pc
    );

    modport slave (
        output redirect_valid, redirect_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output id_ready,
        input  imem_req_valid, imem_req_addr,
        input  id_valid, id_instr, id_pc
    );

endinterface

// File: rtl/if_fifo.sv
// Synchronous FIFO of {pc,instr} with flush; a push is visible at the head the next cycle.
// No internal backpressure: the caller's credit accounting guarantees push never overflows.
module if_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  fetch_pair_t                push_dat_i,
    input  logic                       pop_i,
    output fetch_pair_t                head_dat_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_pair_t     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign do_push = push_i & ~flush_i;
    assign do_pop  = pop_i & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; validity is carried entirely by count_q.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch: issues sequential fetches under a DEPTH credit limit, buffers responses, handles redirects.
// Response-to-decode latency 1 cycle; decode stall holds id_* and throttles new requests via buffer credits.
module if_prefetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] NOP      = NOP_INSTR
) (
    input  logic          clk,
    input  logic          rst_n,
    if_prefetch_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] idle_pc_q, idle_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   fifo_cnt;
    logic [CW:0]     credit_used;
    logic [XLEN-1:0] target_pc;
    logic [XLEN-1:0] rsp_pc;

    logic        redirect;
    logic        req_vld;
    logic        req_hs;
    logic        rsp_acc;
    logic        push;
    logic        pop;
    logic        id_vld;
    fetch_pair_t push_dat;
    fetch_pair_t head_dat;

    assign redirect    = bus.redirect_valid;
    assign target_pc   = word_align(bus.redirect_addr);
    assign credit_used = {1'b0, fifo_cnt} + {1'b0, outst_q};

    assign req_vld = rst_n & ~redirect & (credit_used < (CW+1)'(DEPTH));
    assign req_hs  = req_vld & bus.imem_req_ready;

    // With outst_q == 0 nothing is in flight, so any response is a leftover from before reset.
    assign rsp_acc = bus.imem_rsp_valid & (outst_q != '0);
    assign push    = rsp_acc & (discard_q == '0) & ~redirect;

    // Live requests are contiguous and end just before pc_q, so the oldest one sits outst_q words back.
    assign rsp_pc  = pc_q - (XLEN'(outst_q) << 2);

    assign push_dat.pc    = rsp_pc;
    assign push_dat.instr = bus.imem_rsp_data;

    assign id_vld = (fifo_cnt != '0);
    assign pop    = id_vld & bus.id_ready & ~redirect;

    always_comb begin
        pc_d      = pc_q;
        idle_pc_d = idle_pc_q;
        outst_d   = outst_q + CW'(req_hs) - CW'(rsp_acc);
        discard_d = discard_q;
        if (redirect) begin
            pc_d      = target_pc;
            idle_pc_d = target_pc;
            discard_d = outst_d;
        end else begin
            if (req_hs) pc_d = pc_q + 32'd4;
            if (rsp_acc && discard_q != '0) discard_d = discard_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            idle_pc_q <= RESET_PC;
            outst_q   <= '0;
            discard_q <= '0;
        end else begin
            pc_q      <= pc_d;
            idle_pc_q <= idle_pc_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
        end
    end

    if_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (redirect),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .head_dat_o (head_dat),
        .count_o    (fifo_cnt)
    );

    assign bus.imem_req_valid = req_vld;
    assign bus.imem_req_addr  = pc_q;
    assign bus.id_valid       = id_vld;
    assign bus.id_instr       = id_vld ? head_dat.instr : NOP;
    assign bus.id_pc          = id_vld ? head_dat.pc : idle_pc_q;

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: queue-based reference of fetch order and decode stream, checked every cycle,
// plus literal expectations for reset, first-fetch timing, stall credits, redirects, address wrap and mid-stream reset.
module tb_if_prefetch;
    import cpu_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    if_prefetch_if bus();

    if_prefetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH),
        .NOP      (NOP_INSTR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic        c_rst_n     = 1'b0;
    logic        c_redir     = 1'b0;
    logic [31:0] c_redir_addr = 32'h0;
    logic        c_req_rdy   = 1'b1;
    logic        c_rsp_en    = 1'b1;
    logic        c_id_rdy    = 1'b1;

    // memory side: accepted addresses awaiting a response, and a log of every accepted address
    logic [31:0] mq[$];
    logic [31:0] reqlog[$];

    // reference: outstanding fetches (with stale mark), decode queue of pcs, next fetch address
    typedef struct {
        logic [31:0] pc;
        bit          stale;
    } pend_t;
    pend_t       m_pend[$];
    logic [31:0] m_idq[$];
    logic [31:0] m_pc = RESET_PC;

    int          first_id_cyc = -1;
    bit          cap = 1'b0;
    logic [31:0] cap_pc = 32'hDEAD_BEEF;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:16] ^ 16'hC0DE, a[15:0] ^ 16'h1357};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk_log(input string name, input int idx, input logic [31:0] exp);
        if (idx < reqlog.size()) begin
            chk(name, reqlog[idx], exp);
        end else begin
            checks++;
            errors++;
            $display("FAIL %s: request %0d never issued, expected %h", name, idx, exp);
        end
    endtask

    task automatic step();
        bit    exp_req, exp_idv, rsp_in;
        pend_t p;
        @(negedge clk);
        rst_n              = c_rst_n;
        bus.redirect_valid = c_redir;
        bus.redirect_addr  = c_redir_addr;
        bus.imem_req_ready = c_req_rdy;
        bus.id_ready       = c_id_rdy;
        bus.imem_rsp_valid = c_rsp_en && (mq.size() > 0);
        bus.imem_rsp_data  = (mq.size() > 0) ? mem_word(mq[0]) : 32'h0;
        #1;
        exp_req = rst_n && !c_redir && ((m_idq.size() + m_pend.size()) < DEPTH);
        exp_idv = (m_idq.size() > 0);
        chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
        if (exp_req) chk("req_addr", bus.imem_req_addr, m_pc);
        chk("id_valid", 32'(bus.id_valid), 32'(exp_idv));
        if (exp_idv) begin
            chk("id_pc", bus.id_pc, m_idq[0]);
            chk("id_instr", bus.id_instr, mem_word(m_idq[0]));
        end else begin
            chk("id_instr_nop", bus.id_instr, NOP_INSTR);
        end

        if (bus.id_valid && first_id_cyc < 0) first_id_cyc = cyc;
        if (cap && bus.id_valid) begin
            cap_pc = bus.id_pc;
            cap    = 1'b0;
        end

        if (bus.imem_rsp_valid) void'(mq.pop_front());
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            mq.push_back(bus.imem_req_addr);
            reqlog.push_back(bus.imem_req_addr);
        end

        if (!rst_n) begin
            m_pend.delete();
            m_idq.delete();
            m_pc = RESET_PC;
        end else begin
            rsp_in = bus.imem_rsp_valid && (m_pend.size() > 0);
            if (rsp_in) p = m_pend.pop_front();
            if (c_redir) begin
                m_idq.delete();
                foreach (m_pend[i]) m_pend[i].stale = 1'b1;
                m_pc = c_redir_addr & ~32'h3;
            end else begin
                if (exp_idv && c_id_rdy) void'(m_idq.pop_front());
                if (rsp_in && !p.stale) m_idq.push_back(p.pc);
                if (exp_req && c_req_rdy) begin
                    m_pend.push_back('{pc: m_pc, stale: 1'b0});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic redirect_to(input logic [31:0] addr);
        c_redir      = 1'b1;
        c_redir_addr = addr;
        run(1);
        c_redir = 1'b0;
        cap     = 1'b1;
        cap_pc  = 32'hDEAD_BEEF;
    endtask

    initial begin
        int rel, idx;
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.id_ready       = 1'b0;

        // reset state
        run(3);
        chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
        chk("rst_id_instr", bus.id_instr, 32'h0000_0013);
        chk("rst_id_pc", bus.id_pc, RESET_PC);
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);

        // release: sequential fetch; first id_valid in the third cycle counting the first rst_n=1 cycle as cycle 1
        c_rst_n = 1'b1;
        rel = cyc;
        run(12);
        chk_log("seq_addr0", 0, 32'h0000_0000);
        chk_log("seq_addr1", 1, 32'h0000_0004);
        chk_log("seq_addr2", 2, 32'h0000_0008);
        chk("first_id_cycle", 32'(first_id_cyc), 32'(rel + 2));

        // redirect to an unaligned target with exactly two fetches outstanding
        c_req_rdy = 1'b0;
        run(6);
        c_rsp_en  = 1'b0;
        c_req_rdy = 1'b1;
        idx = reqlog.size();
        run(2);
        c_req_rdy = 1'b0;
        chk("outstanding_before_redir", 32'(reqlog.size() - idx), 32'd2);
        idx = reqlog.size();
        redirect_to(32'h0000_0103);
        c_req_rdy = 1'b1;
        c_rsp_en  = 1'b1;
        run(10);
        chk_log("redir_first_addr", idx, 32'h0000_0100);
        chk("redir_first_id_pc", cap_pc, 32'h0000_0100);

        // redirect while a response is arriving mid-stream
        run(4);
        chk("rsp_pending_at_redir", 32'(mq.size() > 0), 32'd1);
        redirect_to(32'h0000_2000);
        run(10);
        chk("redir2_first_id_pc", cap_pc, 32'h0000_2000);

        // back-to-back redirects with responses held off: stale counts accumulate
        c_rsp_en = 1'b0;
        run(3);
        redirect_to(32'h0000_3000);
        run(2);
        redirect_to(32'h0000_4000);
        c_rsp_en = 1'b1;
        run(14);
        chk("redir3_first_id_pc", cap_pc, 32'h0000_4000);

        // address wrap at the top of the address space
        idx = reqlog.size();
        redirect_to(32'hFFFF_FFF8);
        run(8);
        chk_log("wrap_addr0", idx, 32'hFFFF_FFF8);
        chk_log("wrap_addr1", idx + 1, 32'hFFFF_FFFC);
        chk_log("wrap_addr2", idx + 2, 32'h0000_0000);

        // reset with three fetches in flight; their late responses must be ignored
        c_req_rdy = 1'b0;
        run(6);
        c_rsp_en  = 1'b0;
        c_req_rdy = 1'b1;
        idx = reqlog.size();
        run(3);
        c_req_rdy = 1'b0;
        chk("outstanding_before_rst", 32'(reqlog.size() - idx), 32'd3);
        c_rst_n  = 1'b0;
        c_rsp_en = 1'b1;
        run(1);
        c_rst_n = 1'b1;
        run(1);
        chk("post_rst_id_valid", 32'(bus.id_valid), 32'd0);
        chk("post_rst_id_instr", bus.id_instr, 32'h0000_0013);
        chk("post_rst_id_pc", bus.id_pc, RESET_PC);
        run(3);

        // decode stall: exactly DEPTH fetches, then request valid drops; order kept on release
        c_id_rdy  = 1'b0;
        c_req_rdy = 1'b1;
        idx = reqlog.size();
        run(10);
        chk("stall_req_count", 32'(reqlog.size() - idx), 32'd4);
        chk("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk_log("refetch_addr", idx, RESET_PC);
        chk("stall_head_pc", bus.id_pc, RESET_PC);
        c_id_rdy = 1'b1;
        run(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
